// File: rtl/decoder_pkg.sv
// Shared widths and types for the registered 3-to-8 decoder.
package decoder_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;

  typedef logic [SEL_W-1:0] dec_sel_t;
  typedef logic [OUT_W-1:0] dec_onehot_t;

endpackage : decoder_pkg

// File: rtl/decoder_3_to_8_core.sv
// Combinational one-hot decode of a 3-bit select, gated by an active-high enable.
module decoder_3_to_8_core
  import decoder_pkg::*;
(
  input  dec_sel_t    sel,
  input  logic        en,
  output dec_onehot_t onehot
);

  // An unknown select or enable never matches, so the decode falls back to all zeros.
  always_comb begin
    onehot = '0;
    if (en) begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
        if (sel == SEL_W'(i)) onehot[i] = 1'b1;
      end
    end
  end

endmodule : decoder_3_to_8_core

// File: rtl/decoder_3_to_8.sv
// Registered 3-to-8 line decoder: one-cycle latency, async active-low clear.
module decoder_3_to_8
  import decoder_pkg::*;
(
  input  logic clk,
  output logic Y7,
  output logic Y6,
  output logic Y5,
  output logic Y4,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic en,
  input  logic rst_n
);

  dec_onehot_t next_y;
  dec_onehot_t y_q;

  decoder_3_to_8_core u_core (
    .sel    ({A, B, C}),
    .en     (en),
    .onehot (next_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= next_y;
  end

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_q;

endmodule : decoder_3_to_8

// File: tb/tb_decoder_3_to_8.sv
// Directed and random checks of the registered 3-to-8 decoder.
module tb_decoder_3_to_8;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C, en;
  logic Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0;

  int unsigned total  = 0;
  int unsigned passed = 0;

  decoder_3_to_8 dut (
    .clk   (clk),
    .Y7    (Y7),
    .Y6    (Y6),
    .Y5    (Y5),
    .Y4    (Y4),
    .Y3    (Y3),
    .Y2    (Y2),
    .Y1    (Y1),
    .Y0    (Y0),
    .A     (A),
    .B     (B),
    .C     (C),
    .en    (en),
    .rst_n (rst_n)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] get_y();
    return {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = get_y();
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed Y=%b expected Y=%b", tag, obs, exp);
  endtask

  // Drive inputs on the falling edge, then land just after the next rising edge.
  task automatic cycle(input logic [2:0] s, input logic e);
    @(negedge clk);
    {A, B, C} = s;
    en = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] model;
    logic [2:0] rs;
    logic       re;
    int unsigned ones;

    // Reset held with all inputs high
    rst_n = 1'b0;
    {A, B, C} = 3'b111;
    en = 1'b1;
    #1;
    check("reset_immediate", 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 8'h80);

    // Full sweep, enabled
    for (int i = 0; i < 8; i++) begin
      cycle(3'(i), 1'b1);
      check("sweep_en", 8'(1) << i);
    end

    // Enable gating
    for (int i = 0; i < 8; i++) begin
      cycle(3'(i), 1'b0);
      check("sweep_dis", 8'h00);
    end
    cycle(3'b101, 1'b1);
    check("en_on_101", 8'h20);
    cycle(3'b101, 1'b0);
    check("en_drop_101", 8'h00);

    // Mid-cycle select change must not reach the outputs before the edge
    cycle(3'b010, 1'b1);
    check("mid_before", 8'h04);
    @(negedge clk);
    {A, B, C} = 3'b110;
    #1;
    check("mid_no_glitch", 8'h04);
    @(posedge clk);
    #1;
    check("mid_after", 8'h40);

    // Async reset between edges
    cycle(3'b011, 1'b1);
    check("async_pre", 8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_released_no_edge", 8'h00);
    @(posedge clk);
    #1;
    check("async_redecode", 8'h08);

    // Random stream against a one-cycle-delayed model
    for (int i = 0; i < 200; i++) begin
      rs = 3'($urandom_range(7));
      re = 1'($urandom_range(1));
      model = re ? (8'(1) << rs) : 8'h00;
      cycle(rs, re);
      check("random_model", model);
      ones = 0;
      for (int b = 0; b < 8; b++) ones += int'(get_y() >> b) & 1;
      total++;
      assert (ones <= 1) passed++;
      else $error("FAIL onehot_invariant: observed popcount=%0d expected <=1", ones);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_decoder_3_to_8

// File: doc/decoder_3_to_8.md
Name: decoder_3_to_8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Decodes the 3-bit select {A,B,C} (A = MSB) into eight one-hot, active-high outputs Y7..Y0.
- Outputs are registered on the rising clock edge. Used as a small address/select decoder in clocked control paths.

Parameters:
- None. Width is fixed at 3 select bits and 8 outputs.

Ports:
- clk    input   1  system clock; all state updates on rising edge
- rst_n  input   1  asynchronous, active-low reset
- Y7     output  1  high when enabled and {A,B,C}=3'b111
- Y6     output  1  high when enabled and {A,B,C}=3'b110
- Y5     output  1  high when enabled and {A,B,C}=3'b101
- Y4     output  1  high when enabled and {A,B,C}=3'b100
- Y3     output  1  high when enabled and {A,B,C}=3'b011
- Y2     output  1  high when enabled and {A,B,C}=3'b010
- Y1     output  1  high when enabled and {A,B,C}=3'b001
- Y0     output  1  high when enabled and {A,B,C}=3'b000
- A      input   1  select bit 2 (MSB)
- B      input   1  select bit 1
- C      input   1  select bit 0 (LSB)
- en     input   1  active-high enable

Positional port order: clk, Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, A, B, C, en, rst_n. rst_n is appended last so existing positional instantiations keep their order.

Behaviour:
- Reset: rst_n=0 forces Y7..Y0 to 0 immediately, independent of clk. Outputs hold 0 while rst_n is low.
- Reset release: the first rising clk edge after rst_n goes high loads the decode of the current inputs.
- Decode, combinational part:
  - idx = {A,B,C}.
  - next_Y[i] = en & (idx == i), for i = 0..7.
  - Exactly one bit is high when en=1; all bits are 0 when en=0.
- Register: on each rising clk edge (rst_n high), Y[i] <= next_Y[i]. Latency is 1 cycle from inputs to outputs.
- Output stability: inputs may change at any time between edges. Outputs change only on a rising edge or on reset assertion, never combinationally from A/B/C/en.
- One-hot invariant: at most one Y is high at any time after reset.
- X handling: if any of A, B, C or en is X/Z at the sampling edge, all outputs load 0. Simulation only; no synthesis impact.
- Reset mid-operation: asserting rst_n low while an output is high clears it asynchronously. The next decode occurs on the first edge after release.
- No internal state besides the 8 output flops.

Decomposition:
- Shared package decoder_pkg:
  - localparam SEL_W = 3
  - localparam OUT_W = 8
  - typedef logic [SEL_W-1:0] dec_sel_t
  - typedef logic [OUT_W-1:0] dec_onehot_t
- Sub-module decoder_3_to_8_core: purely combinational; inputs dec_sel_t sel and en; output dec_onehot_t onehot.
- The top-level block instantiates the core and adds the async-reset output register. It maps onehot[7:0] to Y7..Y0.

Test Plan:
- Reset: drive rst_n=0 with A,B,C,en = 1,1,1,1 -> Y7..Y0 = 00000000 immediately and through 3 clock edges. Release rst_n -> after the next posedge, Y7..Y0 = 10000000.
- Full sweep enabled: en=1, {A,B,C} stepped 000..111, one value per cycle. After each edge, Y equals the one-hot of the previous cycle's select (000 -> Y0=1 ... 111 -> Y7=1). All others are 0.
- Enable gating: en=0 with each of the 8 select values -> all Y = 0 after every edge. Toggling en 1->0 with {A,B,C}=101 -> Y5 drops on the next edge.
- Mid-cycle input change: change {A,B,C} from 010 to 110 halfway between edges -> Y2 stays high until the next posedge, then Y6=1 and Y2=0. No glitch between edges.
- Async reset mid-operation: with Y3=1, pull rst_n low between edges -> Y3 clears without a clock edge. After release with inputs 011 and en=1 -> Y3=1 again at the next posedge.
- Invariant check: 200 random cycles of {A,B,C,en} with a scoreboard model -> popcount(Y) <= 1 always, and Y matches the model delayed by 1 cycle.
